// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Load-use stall, ID forwarding, branch flush and memory-wait
//             freeze controller for a five-stage MIPS pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rd,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt_total
);

    // Wide enough to hold TIMEOUT itself, so the increment never wraps.
    localparam int c_WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT_V = c_WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                w_hold;
    logic                w_lu;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    r_wait_total;

    // EXE ALU result beats MEM; a MEM-stage load selects the load data path.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       exw,
        input logic       exm,
        input logic [4:0] exrd,
        input logic       memw,
        input logic       memm,
        input logic [4:0] memrd
    );
        if (exw && !exm && (exrd != 5'd0) && (exrd == src))
            return 2'b01;
        else if (memw && (memrd != 5'd0) && (memrd == src))
            return memm ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_lu = ex_wreg & ex_m2reg & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    assign w_wait_inc = r_wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_hold      = 1'b0;
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        mem_timeout = 1'b0;
        fwd_a       = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd);
        fwd_b       = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd);

        case (r_state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    w_hold      = 1'b1;
                    w_wait_nxt  = c_WAIT_W'(1);
                    w_state_nxt = (TIMEOUT <= 1) ? ERR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = RUN;
                end else begin
                    w_hold      = 1'b1;
                    w_wait_nxt  = w_wait_inc;
                    if (w_wait_inc >= c_TIMEOUT_V)
                        w_state_nxt = ERR;
                end
            end
            ERR: begin
                w_hold      = 1'b1;
                mem_timeout = 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase

        // Hold outranks load-use, which outranks the branch flush.
        if (w_hold) begin
            pipe_hold  = 1'b1;
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
        end else if (w_lu) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
        end

        if (rst) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
            mem_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_wait_total <= '0;
        end else begin
            if (idex_bubble && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (ifid_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (pipe_hold && (r_wait_total != '1))
                r_wait_total <= r_wait_total + 1'b1;
        end
    end

    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;
    assign wait_cnt_total = r_wait_total;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Directed self-checking bench for pipeline_hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_TIMEOUT = 8;
    localparam int c_CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
    logic             id_uses_rt, id_branch_taken;
    logic             ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic             mem_req, mem_ready;
    logic             pc_wr_en, ifid_wr_en, ifid_flush, idex_bubble, pipe_hold;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_timeout;
    logic [c_CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt_total;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(c_TIMEOUT), .CNT_W(c_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_total(wait_cnt_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rd = 5'd0;
        mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_rd = 5'd0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        // Reset forces outputs even with hazards presented on the inputs
        rst = 1'b1;
        idle();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
        mem_req = 1'b1; id_branch_taken = 1'b1;
        mem_wreg = 1'b1; mem_rd = 5'd3;
        settle();
        check("rst_pc_wr_en", pc_wr_en, 0);
        check("rst_ifid_wr_en", ifid_wr_en, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_idex_bubble", idex_bubble, 1);
        check("rst_pipe_hold", pipe_hold, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_mem_timeout", mem_timeout, 0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("idle_pc_wr_en", pc_wr_en, 1);
        check("idle_stall_cnt", stall_cnt, 0);
        check("idle_wait_total", wait_cnt_total, 0);

        // Load-use on rs: one bubble then MEM load forwarding
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd2; id_rs = 5'd2;
        settle();
        check("lu_pc_wr_en", pc_wr_en, 0);
        check("lu_ifid_wr_en", ifid_wr_en, 0);
        check("lu_bubble", idex_bubble, 1);
        check("lu_hold", pipe_hold, 0);
        tick();
        check("lu_stall_cnt", stall_cnt, 1);
        idle();
        id_rs = 5'd2; mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rd = 5'd2;
        settle();
        check("lu_fwd_a_load", fwd_a, 2'b11);
        check("lu_after_bubble", idex_bubble, 0);
        check("lu_after_pc", pc_wr_en, 1);
        tick();

        // Load-use on rt only counts when rt is a real source
        idle();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
        settle();
        check("rt_unused_bubble", idex_bubble, 0);
        id_uses_rt = 1'b1;
        settle();
        check("rt_used_bubble", idex_bubble, 1);
        tick();

        // Forwarding priority and $0 exclusion
        idle();
        ex_wreg = 1'b1; ex_rd = 5'd5; mem_wreg = 1'b1; mem_rd = 5'd5;
        id_rs = 5'd5; id_rt = 5'd5;
        settle();
        check("fwd_a_ex_prio", fwd_a, 2'b01);
        check("fwd_b_ex_prio", fwd_b, 2'b01);
        ex_wreg = 1'b0;
        settle();
        check("fwd_a_mem_alu", fwd_a, 2'b10);
        idle();
        ex_wreg = 1'b1; mem_wreg = 1'b1; mem_m2reg = 1'b1;
        settle();
        check("fwd_a_r0", fwd_a, 2'b00);
        check("fwd_b_r0", fwd_b, 2'b00);
        tick();

        // Branch coinciding with load-use is not flushed until the stall clears
        idle();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        id_branch_taken = 1'b1;
        settle();
        check("br_lu_flush", ifid_flush, 0);
        check("br_lu_bubble", idex_bubble, 1);
        tick();
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rd = 5'd0;
        settle();
        check("br_flush", ifid_flush, 1);
        check("br_pc_wr_en", pc_wr_en, 1);
        tick();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 3);

        // Memory wait of 3 cycles, with hold masking a load-use and a branch
        idle();
        do_reset();
        mem_req = 1'b1;
        settle();
        check("mw_hold_c1", pipe_hold, 1);
        check("mw_pc_c1", pc_wr_en, 0);
        tick();
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_branch_taken = 1'b1;
        settle();
        check("mw_hold_c2", pipe_hold, 1);
        check("mw_bubble_masked", idex_bubble, 0);
        check("mw_flush_masked", ifid_flush, 0);
        check("mw_ifid_wr_c2", ifid_wr_en, 0);
        tick();
        idle();
        mem_req = 1'b1;
        settle();
        check("mw_hold_c3", pipe_hold, 1);
        tick();
        mem_ready = 1'b1;
        settle();
        check("mw_hold_ready", pipe_hold, 0);
        check("mw_pc_ready", pc_wr_en, 1);
        tick();
        idle();
        settle();
        check("mw_wait_total", wait_cnt_total, 3);
        check("mw_back_run", pipe_hold, 0);
        check("mw_stall_masked_cnt", stall_cnt, 0);

        // Request and ready together in RUN: no hold, stays in RUN
        mem_req = 1'b1; mem_ready = 1'b1;
        settle();
        check("rr_hold", pipe_hold, 0);
        tick();
        idle();
        settle();
        check("rr_still_run", pipe_hold, 0);
        check("rr_wait_total", wait_cnt_total, 3);

        // Watchdog: 8 wait cycles lead to a sticky timeout
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < c_TIMEOUT; i++) begin
            settle();
            check($sformatf("wd_hold_%0d", i), pipe_hold, 1);
            check($sformatf("wd_no_to_%0d", i), mem_timeout, 0);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("wd_timeout", mem_timeout, 1);
        check("wd_hold_err", pipe_hold, 1);
        check("wd_pc_err", pc_wr_en, 0);
        tick();
        check("wd_timeout_sticky", mem_timeout, 1);
        check("wd_wait_total", wait_cnt_total, 9);
        rst = 1'b1;
        settle();
        check("wd_rst_timeout", mem_timeout, 0);
        check("wd_rst_hold", pipe_hold, 0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("wd_post_rst_to", mem_timeout, 0);
        check("wd_post_rst_hold", pipe_hold, 0);
        check("wd_post_rst_wait", wait_cnt_total, 0);

        // Stall counter saturates at 15 for a 4-bit width
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = 5'd6; id_rs = 5'd6;
        for (int i = 0; i < 20; i++)
            tick();
        check("sat_stall_cnt", stall_cnt, 15);
        check("sat_flush_cnt", flush_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
